// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.t stopwatch and its seven-segment decode.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } sw_state_t;

  // Field order matches the bcd_o bus, most significant digit first.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } digits_t;

  localparam logic [3:0] TENTHS_MAX   = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment word ({g,f,e,d,c,b,a}); non-BCD codes blank the digit.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch MM:SS.t with run/pause/clear control, lap freeze and five active-low HEX digits.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT = 59
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_i,
  input  logic        start_stop_i,
  input  logic        lap_i,
  input  logic        clear_i,
  output logic        running_o,
  output logic        lapped_o,
  output logic        overflow_o,
  output logic [19:0] bcd_o,
  output logic [34:0] hex_o
);

  localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_ONES_LIM = 4'(MIN_LIMIT % 10);

  sw_state_t state, state_n;
  digits_t   digits, digits_n, inc, latch, latch_n;
  logic      lapped_n, wrap, count_en, overflow_n;
  logic      start_q, lap_q, clear_q;
  logic      ss_edge, lap_edge, clear_edge;

  assign ss_edge    = start_stop_i & ~start_q;
  assign lap_edge   = lap_i & ~lap_q;
  assign clear_edge = clear_i & ~clear_q;

  // One-tick increment of the whole chain, carries rippling within the cycle.
  always_comb begin
    inc  = digits;
    wrap = 1'b0;
    if (digits.tenths != TENTHS_MAX) begin
      inc.tenths = digits.tenths + 4'd1;
    end else begin
      inc.tenths = '0;
      if (digits.sec_ones != SEC_ONES_MAX) begin
        inc.sec_ones = digits.sec_ones + 4'd1;
      end else begin
        inc.sec_ones = '0;
        if (digits.sec_tens != SEC_TENS_MAX) begin
          inc.sec_tens = digits.sec_tens + 4'd1;
        end else begin
          inc.sec_tens = '0;
          if (digits.min_tens == MIN_TENS_LIM && digits.min_ones == MIN_ONES_LIM) begin
            inc.min_tens = '0;
            inc.min_ones = '0;
            wrap         = 1'b1;
          end else if (digits.min_ones == 4'd9) begin
            inc.min_ones = '0;
            inc.min_tens = digits.min_tens + 4'd1;
          end else begin
            inc.min_ones = digits.min_ones + 4'd1;
          end
        end
      end
    end
  end

  // Ticks use the state before this edge, so the RUN->PAUSE tick counts and the ->RUN tick does not.
  always_comb begin
    count_en   = tick_i && (state == RUN);
    digits_n   = count_en ? inc : digits;
    overflow_n = count_en & wrap;
    state_n    = state;
    lapped_n   = lapped_o;
    latch_n    = latch;
    case (state)
      IDLE: begin
        if (ss_edge) state_n = RUN;
      end
      RUN: begin
        if (ss_edge) begin
          state_n = PAUSE;
        end else if (lap_edge) begin
          if (lapped_o) begin
            lapped_n = 1'b0;
          end else begin
            lapped_n = 1'b1;
            latch_n  = digits_n;
          end
        end
      end
      PAUSE: begin
        if (clear_edge) begin
          state_n  = IDLE;
          digits_n = '0;
          lapped_n = 1'b0;
        end else begin
          if (ss_edge) state_n = RUN;
          if (lap_edge && lapped_o) lapped_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      digits     <= '0;
      latch      <= '0;
      lapped_o   <= 1'b0;
      overflow_o <= 1'b0;
      running_o  <= 1'b0;
      bcd_o      <= '0;
      start_q    <= 1'b0;
      lap_q      <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state      <= state_n;
      digits     <= digits_n;
      latch      <= latch_n;
      lapped_o   <= lapped_n;
      overflow_o <= overflow_n;
      running_o  <= (state_n == RUN);
      bcd_o      <= lapped_n ? latch_n : digits_n;
      start_q    <= start_stop_i;
      lap_q      <= lap_i;
      clear_q    <= clear_i;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_dec
    seg7_decoder u_dec (
      .bcd (bcd_o[4*i +: 4]),
      .seg (hex_o[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: vector table, hand sequences and a random run against a tenths-count model.
module tb_stopwatch_bcd;

  localparam int MIN_LIMIT   = 59;
  localparam int LIMIT_TOTAL = (MIN_LIMIT + 1) * 600;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_i = 1'b0;
  logic        start_stop_i = 1'b0;
  logic        lap_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        running_o, lapped_o, overflow_o;
  logic [19:0] bcd_o;
  logic [34:0] hex_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: elapsed time as a plain count of tenths, plus mode flags.
  int   m_mode = 0;
  int   m_count = 0;
  int   m_latch = 0;
  logic m_lapped = 1'b0;
  logic m_ovf = 1'b0;
  logic m_ss_q = 1'b0, m_lp_q = 1'b0, m_cl_q = 1'b0;

  logic [6:0] seg_table [10];

  typedef struct {
    logic        rn, ss, lp, cl, tk;
    logic [19:0] bcd;
    logic        run, lap;
  } vec_t;

  vec_t vecs [24];

  stopwatch_bcd #(.MIN_LIMIT(MIN_LIMIT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick_i       (tick_i),
    .start_stop_i (start_stop_i),
    .lap_i        (lap_i),
    .clear_i      (clear_i),
    .running_o    (running_o),
    .lapped_o     (lapped_o),
    .overflow_o   (overflow_o),
    .bcd_o        (bcd_o),
    .hex_o        (hex_o)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int total);
    int mins, secs, tenth;
    mins  = total / 600;
    secs  = (total / 10) % 60;
    tenth = total % 10;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(tenth)};
  endfunction

  function automatic logic [34:0] to_hex(input logic [19:0] b);
    logic [34:0] h;
    for (int i = 0; i < 5; i++) h[7*i +: 7] = seg_table[int'(b[4*i +: 4])];
    return h;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 idle, 1 running, 2 paused
  task automatic modelStep(input logic rn, input logic ss, input logic lp, input logic cl, input logic tk);
    logic ss_e, lp_e, cl_e;
    if (!rn) begin
      m_mode = 0; m_count = 0; m_latch = 0; m_lapped = 1'b0; m_ovf = 1'b0;
      m_ss_q = 1'b0; m_lp_q = 1'b0; m_cl_q = 1'b0;
      return;
    end
    ss_e = ss & ~m_ss_q;
    lp_e = lp & ~m_lp_q;
    cl_e = cl & ~m_cl_q;
    m_ovf = 1'b0;
    if (tk && m_mode == 1) begin
      m_count++;
      if (m_count == LIMIT_TOTAL) begin
        m_count = 0;
        m_ovf   = 1'b1;
      end
    end
    if (m_mode == 0) begin
      if (ss_e) m_mode = 1;
    end else if (m_mode == 1) begin
      if (ss_e) m_mode = 2;
      else if (lp_e) begin
        if (m_lapped) m_lapped = 1'b0;
        else begin
          m_lapped = 1'b1;
          m_latch  = m_count;
        end
      end
    end else begin
      if (cl_e) begin
        m_mode = 0; m_count = 0; m_lapped = 1'b0;
      end else begin
        if (ss_e) m_mode = 1;
        if (lp_e && m_lapped) m_lapped = 1'b0;
      end
    end
    m_ss_q = ss; m_lp_q = lp; m_cl_q = cl;
  endtask

  task automatic checkOutput();
    logic [19:0] exp_bcd;
    exp_bcd = to_bcd(m_lapped ? m_latch : m_count);
    cmp("bcd", 64'(bcd_o), 64'(exp_bcd));
    cmp("hex", 64'(hex_o), 64'(to_hex(exp_bcd)));
    cmp("running", 64'(running_o), 64'(m_mode == 1));
    cmp("lapped", 64'(lapped_o), 64'(m_lapped));
    cmp("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  task automatic applyStimulus(input logic rn, input logic ss, input logic lp, input logic cl, input logic tk);
    reset_n = rn; start_stop_i = ss; lap_i = lp; clear_i = cl; tick_i = tk;
    @(posedge clk);
    modelStep(rn, ss, lp, cl, tk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    seg_table = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    //            rn    ss    lp    cl    tk    bcd        run   lap
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00001, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00002, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00002, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00002, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00002, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00004, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00004, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00004, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'h00005, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00005, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00005, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00006, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00006, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00001, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00001, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0};

    $display("[TB] vector table");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rn, vecs[i].ss, vecs[i].lp, vecs[i].cl, vecs[i].tk);
      cmp($sformatf("vec%0d_bcd", i), 64'(bcd_o), 64'(vecs[i].bcd));
      cmp($sformatf("vec%0d_run", i), 64'(running_o), 64'(vecs[i].run));
      cmp($sformatf("vec%0d_lap", i), 64'(lapped_o), 64'(vecs[i].lap));
    end

    $display("[TB] 00:12.5 with start_stop held");
    doReset();
    cmp("reset_hex", 64'(hex_o), {29'd0, {5{7'b1000000}}});
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 125; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("count_125", 64'(bcd_o), 64'(20'h00125));
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("held_ss_bcd", 64'(bcd_o), 64'(20'h00135));
    cmp("held_ss_run", 64'(running_o), 64'(1'b1));

    $display("[TB] lap freeze");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp("lap_frozen_bcd", 64'(bcd_o), 64'(20'h00030));
    cmp("lap_frozen_flag", 64'(lapped_o), 64'(1'b1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("lap_release_bcd", 64'(bcd_o), 64'(20'h00050));

    $display("[TB] overflow wrap");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 35998; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("preload_bcd", 64'(bcd_o), 64'(20'h59598));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("pre_wrap_ovf", 64'(overflow_o), 64'(1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("wrap_bcd", 64'(bcd_o), 64'(20'h00000));
    cmp("wrap_ovf", 64'(overflow_o), 64'(1'b1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("post_wrap_bcd", 64'(bcd_o), 64'(20'h00001));
    cmp("post_wrap_ovf", 64'(overflow_o), 64'(1'b0));
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("midcount_reset_bcd", 64'(bcd_o), 64'(20'h00000));
    cmp("midcount_reset_ovf", 64'(overflow_o), 64'(1'b0));
    cmp("midcount_reset_run", 64'(running_o), 64'(1'b0));

    $display("[TB] random run");
    doReset();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 7) == 0),
                    logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 11) == 0),
                    logic'($urandom_range(0, 1)));
    end

    $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
